regfile_bank32: RTL and testbench

- 32-entry, 64-bit integer register file (X0–X31) that sits directly downstream of the 5:32 write-enable decoder.
- Takes the decoder's 32-bit write-enable bus plus writeback data and commits data on the rising clock edge.
- Provides two read ports for the decode stage.
- X31 (XZR) is hardwired to zero.
- Write-through bypass lets a same-cycle writeback be visible on the read ports, so the pipeline needs no WB->ID forwarding.
- A sticky fault flag records any illegal multi-hot write-enable pattern.

---
 rtl/regfile_bank32.sv | 87 ++++++++
 tb/tb_regfile_bank32.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regfile_bank32.sv
// 32 x 64-bit integer register file fed by a one-hot write-enable bus.
// XZR reads zero, same-cycle writes bypass to the read ports, multi-hot writes raise a sticky fault.
module regfile_bank32 #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREGS-1:0]  wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        rd_addr1,
    input  logic [4:0]        rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              wen_fault
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [DATA_W-1:0] w_regs [NREGS];
    logic              w_multi_hot;
    logic              r_fault;

    // Storage: one flop bank per writable register, none for the zero register.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (gi == ZERO_REG) begin : g_zero
            assign w_regs[gi] = {DATA_W{1'b0}};
        end else begin : g_ff
            logic [DATA_W-1:0] r_q;

            // Register update: reset wins over any enabled write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= {DATA_W{1'b0}};
                end else if (wr_en[gi]) begin
                    r_q <= wr_data;
                end else begin
                    r_q <= r_q;
                end
            end

            assign w_regs[gi] = r_q;
        end
    end

    // More than one bit set exactly when clearing the lowest set bit leaves something behind.
    assign w_multi_hot = |(wr_en & (wr_en - {{(NREGS-1){1'b0}}, 1'b1}));

    // Sticky multi-hot fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_multi_hot) begin
            r_fault <= 1'b1;
        end else begin
            r_fault <= r_fault;
        end
    end

    assign wen_fault = r_fault;

    // Read port 1: zero register, then write-through bypass, then storage.
    always_comb begin
        rd_data1 = {DATA_W{1'b0}};
        if (reset || (rd_addr1 == ZERO_IDX)) begin
            rd_data1 = {DATA_W{1'b0}};
        end else if (wr_en[rd_addr1]) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = w_regs[rd_addr1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd_data2 = {DATA_W{1'b0}};
        if (reset || (rd_addr2 == ZERO_IDX)) begin
            rd_data2 = {DATA_W{1'b0}};
        end else if (wr_en[rd_addr2]) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = w_regs[rd_addr2];
        end
    end

endmodule

// File: tb/tb_regfile_bank32.sv
// Self-checking bench for regfile_bank32: directed plan steps followed by random traffic,
// compared against an array-based reference model of the register file.
module tb_regfile_bank32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wr_en;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;
    logic        wen_fault;

    logic [63:0] m_regs [32];
    logic        m_fault;
    int          n_tests = 0;
    int          n_fail  = 0;

    regfile_bank32 #(.DATA_W(64), .NREGS(32), .ZERO_REG(31)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .wen_fault (wen_fault)
    );

    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // What a read should return given the current inputs and the architectural state.
    function automatic logic [63:0] model_read(input logic [4:0] addr);
        if (reset)                  return 64'd0;
        if (addr == 5'd31)          return 64'd0;
        if (wr_en[addr])            return wr_data;
        return m_regs[addr];
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            m_fault = 1'b0;
        end else begin
            for (int i = 0; i < 31; i++) if (wr_en[i]) m_regs[i] = wr_data;
            if ($countones(wr_en) > 1) m_fault = 1'b1;
        end
    endtask

    // Apply one cycle of inputs, check the combinational reads before the edge, then clock.
    task automatic step(input logic rst, input logic [31:0] we, input logic [63:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2);
        reset    = rst;
        wr_en    = we;
        wr_data  = wd;
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
        check64("rd1", rd_data1, model_read(a1));
        check64("rd2", rd_data2, model_read(a2));
        check1("fault", wen_fault, m_fault);
        @(posedge clk);
        model_edge();
        #2;
    endtask

    initial begin
        logic [31:0] we;
        for (int i = 0; i < 32; i++) m_regs[i] = 64'hBAD0_BAD0_BAD0_BAD0;
        m_fault  = 1'bx;
        reset    = 1'b1;
        wr_en    = 32'd0;
        wr_data  = 64'd0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        @(posedge clk);
        model_edge();
        #2;

        // Every index reads zero after reset.
        for (int i = 0; i < 32; i++) step(1'b0, 32'd0, 64'd0, 5'(i), 5'(31 - i));
        check1("reset_fault", wen_fault, 1'b0);

        // Single write to X8, neighbours untouched.
        step(1'b0, 32'h0000_0100, 64'hDEAD_BEEF_0000_0008, 5'd8, 5'd7);
        step(1'b0, 32'd0, 64'd0, 5'd8, 5'd7);
        check64("x8_stored", rd_data1, 64'hDEAD_BEEF_0000_0008);
        check64("x7_zero", rd_data2, 64'd0);
        step(1'b0, 32'd0, 64'd0, 5'd9, 5'd8);
        check64("x9_zero", rd_data1, 64'd0);

        // Bypass on both ports for X5, then from storage.
        reset = 1'b0; wr_en = 32'h0000_0020; wr_data = 64'h55; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        #1;
        check64("x5_bypass1", rd_data1, 64'h55);
        check64("x5_bypass2", rd_data2, 64'h55);
        @(posedge clk); model_edge(); #2;
        step(1'b0, 32'd0, 64'd0, 5'd5, 5'd5);
        check64("x5_stored", rd_data2, 64'h55);

        // Writes to XZR are dropped and are not a fault.
        step(1'b0, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        step(1'b0, 32'd0, 64'd0, 5'd31, 5'd30);
        check64("xzr_zero", rd_data1, 64'd0);
        check1("xzr_nofault", wen_fault, 1'b0);

        // Multi-hot write hits both registers and latches the fault until reset.
        step(1'b0, 32'h0000_0003, 64'h7, 5'd0, 5'd1);
        step(1'b0, 32'd0, 64'd0, 5'd0, 5'd1);
        check64("x0_multi", rd_data1, 64'h7);
        check64("x1_multi", rd_data2, 64'h7);
        check1("fault_set", wen_fault, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd1 << (2 * i + 10), 64'(i), 5'(i), 5'(2 * i + 10));
        check1("fault_sticky", wen_fault, 1'b1);
        step(1'b1, 32'd0, 64'd0, 5'd0, 5'd1);
        step(1'b0, 32'd0, 64'd0, 5'd0, 5'd1);
        check1("fault_cleared", wen_fault, 1'b0);

        // Reset beats a simultaneous write to X3.
        step(1'b0, 32'h0000_0008, 64'hA5, 5'd3, 5'd3);
        reset = 1'b1; wr_en = 32'h0000_0008; wr_data = 64'h99; rd_addr1 = 5'd3; rd_addr2 = 5'd3;
        #1;
        check64("x3_during_reset", rd_data1, 64'd0);
        @(posedge clk); model_edge(); #2;
        step(1'b0, 32'd0, 64'd0, 5'd3, 5'd3);
        check64("x3_after_reset", rd_data1, 64'd0);

        // Random traffic: mostly one-hot or idle, occasionally multi-hot or reset.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(9))
                0:       we = 32'd0;
                1:       we = $urandom;
                default: we = 32'd1 << $urandom_range(31);
            endcase
            step(($urandom_range(60) == 0), we, {$urandom, $urandom},
                 5'($urandom_range(31)), 5'($urandom_range(31)));
        end

        // Final sweep of the whole file from storage.
        for (int i = 0; i < 32; i++) step(1'b0, 32'd0, 64'd0, 5'(i), 5'(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
